// File: rtl/ysyx_23060136_exu_alu_stage.sv
// EXU ALU stage: one-slot registered pipeline stage that computes the integer ALU result
// and hands it downstream under valid/ready. Also holds the barrel shifter it uses.

module ysyx_23060136_EXU_SHIFT #(
    parameter int W = 32,
    parameter int S = 5
) (
    input  logic [W-1:0] din,
    input  logic [S-1:0] shamt,
    input  logic         LR,     // 1: shift left, 0: shift right
    input  logic         AL,     // 1: arithmetic (sign fill) on right shifts
    output logic [W-1:0] dout
);
    logic [W-1:0] din_rev;
    logic [W-1:0] res_rev;
    logic [W-1:0] stage [0:S];
    logic         fill;

    // Left shifts reuse the right-shift network on a bit-reversed operand.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_rev
            assign din_rev[gi] = din[W-1-gi];
            assign res_rev[gi] = stage[S][W-1-gi];
        end
    endgenerate

    assign fill     = AL & ~LR & din[W-1];
    assign stage[0] = LR ? din_rev : din;

    generate
        for (gi = 0; gi < S; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = shamt[gi] ? {{SH{fill}}, stage[gi][W-1:SH]} : stage[gi];
        end
    endgenerate

    assign dout = LR ? res_rev : stage[S];
endmodule

module ysyx_23060136_exu_alu_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int RD_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              idu_valid,
    output logic              idu_ready,
    input  logic [DATA_W-1:0] idu_pc,
    input  logic [DATA_W-1:0] idu_src1,
    input  logic [DATA_W-1:0] idu_src2,
    input  logic [3:0]        idu_alu_op,
    input  logic [RD_W-1:0]   idu_rd,
    input  logic              idu_wb_en,
    output logic              exu_valid,
    input  logic              exu_ready,
    output logic [DATA_W-1:0] exu_pc,
    output logic [DATA_W-1:0] exu_result,
    output logic [RD_W-1:0]   exu_rd,
    output logic              exu_wb_en,
    output logic              exu_illegal,
    output logic [31:0]       exu_fire_cnt
);
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic [RD_W-1:0]   rd_q,      rd_d;
    logic              wb_en_q,   wb_en_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       cnt_q,     cnt_d;

    logic              in_fire;
    logic              out_fire;
    logic              op_legal;
    logic [DATA_W-1:0] shift_res;
    logic [DATA_W-1:0] alu_res;

    assign idu_ready = ~flush & (~valid_q | exu_ready);
    assign in_fire   = idu_valid & idu_ready;
    assign out_fire  = valid_q & exu_ready;
    assign op_legal  = (idu_alu_op <= OP_PASSB);

    ysyx_23060136_EXU_SHIFT #(
        .W (DATA_W),
        .S (SHAMT_W)
    ) u_shift (
        .din   (idu_src1),
        .shamt (idu_src2[SHAMT_W-1:0]),
        .LR    (idu_alu_op == OP_SLL),
        .AL    (idu_alu_op == OP_SRA),
        .dout  (shift_res)
    );

    always_comb begin
        alu_res = '0;
        case (idu_alu_op)
            OP_ADD:   alu_res = idu_src1 + idu_src2;
            OP_SUB:   alu_res = idu_src1 - idu_src2;
            OP_SLL,
            OP_SRL,
            OP_SRA:   alu_res = shift_res;
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(idu_src1) < $signed(idu_src2))};
            OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (idu_src1 < idu_src2)};
            OP_XOR:   alu_res = idu_src1 ^ idu_src2;
            OP_OR:    alu_res = idu_src1 | idu_src2;
            OP_AND:   alu_res = idu_src1 & idu_src2;
            OP_PASSB: alu_res = idu_src2;
            default:  alu_res = '0;
        endcase
    end

    // Flush wins over a new op; the counter still sees a handshake that coincides with flush.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        result_d  = result_q;
        rd_d      = rd_q;
        wb_en_d   = wb_en_q;
        illegal_d = illegal_q;
        cnt_d     = out_fire ? cnt_q + 32'd1 : cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d   = 1'b1;
            pc_d      = idu_pc;
            result_d  = alu_res;
            rd_d      = idu_rd;
            wb_en_d   = idu_wb_en & op_legal;
            illegal_d = ~op_legal;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            wb_en_q   <= wb_en_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign exu_valid    = valid_q;
    assign exu_pc       = pc_q;
    assign exu_result   = result_q;
    assign exu_rd       = rd_q;
    assign exu_wb_en    = wb_en_q;
    assign exu_illegal  = illegal_q;
    assign exu_fire_cnt = cnt_q;
endmodule

// File: doc/ysyx_23060136_exu_alu_stage.md
Name: ysyx_23060136_exu_alu_stage

Overview:
Single-slot EXU pipeline stage between the IDU and the LSU/WBU.
- Accepts one decoded integer instruction per handshake and computes the ALU result.
- Shift ops are computed by instantiating the team barrel shifter ysyx_23060136_EXU_SHIFT.
- The result and writeback controls are registered, then presented downstream under a valid/ready handshake.
- Supports pipeline flush and keeps a retired-op counter.

Parameters:
DATA_W, 32, operand/result width (equals `ysyx_23060136_BITS_W)
SHAMT_W, 5, shift-amount width (equals `ysyx_23060136_BITS_S)
RD_W, 5, destination register index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  kill the in-flight op and block acceptance this cycle
idu_valid  in  1  upstream op valid
idu_ready  out  1  stage can accept this cycle
idu_pc  in  DATA_W  PC of the op
idu_src1  in  DATA_W  operand A
idu_src2  in  DATA_W  operand B (immediate already muxed in)
idu_alu_op  in  4  operation code, see Behaviour
idu_rd  in  RD_W  destination register
idu_wb_en  in  1  register writeback enable
exu_valid  out  1  registered result valid
exu_ready  in  1  downstream accepts
exu_pc  out  DATA_W  registered PC
exu_result  out  DATA_W  registered ALU result
exu_rd  out  RD_W  registered rd
exu_wb_en  out  1  registered writeback enable (forced 0 for illegal op)
exu_illegal  out  1  registered flag: op code was 11..15
exu_fire_cnt  out  32  count of downstream handshakes

Behaviour:
Reset:
- rst=1 at a clock edge sets every registered output to 0: exu_valid, exu_pc, exu_result, exu_rd, exu_wb_en, exu_illegal, exu_fire_cnt.
- idu_ready is combinational. It is 1 after reset, because the output slot is empty.

Handshakes:
- in_fire = idu_valid & idu_ready.
- out_fire = exu_valid & exu_ready.
- idu_ready = !flush & (!exu_valid | exu_ready). This gives full throughput (one op per cycle) when downstream is always ready.

Latency and hold:
- Latency is 1 cycle. On in_fire at edge N, the result is visible on the exu_* outputs after edge N with exu_valid=1.
- While exu_valid=1 and exu_ready=0, all exu_* outputs hold stable.

Slot update priority per edge:
1. rst
2. flush: exu_valid<=0; data regs may hold
3. in_fire: load all regs, exu_valid<=1
4. out_fire without in_fire: exu_valid<=0
5. otherwise hold

Simultaneous events:
- flush and exu_ready=1 in the same cycle: the op is still counted if exu_valid was 1 (out_fire is evaluated before the kill).
- flush with idu_valid=1: the incoming op is not accepted. Upstream must hold or re-issue it.

ALU ops (idu_alu_op):
- 0 ADD: src1+src2, mod 2^DATA_W
- 1 SUB: src1-src2, mod 2^DATA_W
- 2 SLL
- 3 SLT: signed compare, result 1/0
- 4 SLTU: unsigned compare, result 1/0
- 5 XOR
- 6 SRL
- 7 SRA
- 8 OR
- 9 AND
- 10 PASSB: result = src2
- 11..15: result 0, exu_illegal=1, exu_wb_en=0

Shift wiring:
- Shift amount is src2[SHAMT_W-1:0]. Upper bits of src2 are ignored.
- Shifter controls: SLL uses LR=1,AL=0; SRL uses LR=0,AL=0; SRA uses LR=0,AL=1.

Writeback:
- exu_wb_en is registered as idu_wb_en & legal-op.
- rd=0 is passed through unchanged; writeback suppression for x0 is the WBU's job.

Counter:
- exu_fire_cnt increments by 1 on every out_fire and wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1 with exu_ready=1: exu_valid rises one cycle after in_fire; exu_result=0x80000000; exu_fire_cnt becomes 1 on the next edge.
- SRA src1=0x80000000, src2=0x0000_0024 (shamt 4): result 0xF8000000. SRL same operands: result 0x08000000. SLL src1=1, src2=31: result 0x80000000.
- SLT src1=0xFFFFFFFF, src2=1 gives 1; SLTU with the same operands gives 0; SUB 0-1 gives 0xFFFFFFFF.
- Back-pressure: hold exu_ready=0 for 3 cycles with idu_valid=1. Required: idu_ready=0 and exu_* outputs stable throughout. On exu_ready=1, new op accepted the same cycle, giving back-to-back outputs with no bubble.
- Flush while exu_valid=1 and exu_ready=0: exu_valid=0 next cycle, idu_ready=0 during the flush cycle, exu_fire_cnt unchanged.
- Illegal op 13 with idu_wb_en=1: exu_illegal=1, exu_wb_en=0, exu_result=0. Then assert rst mid-stream: all outputs are 0 after the edge and exu_fire_cnt=0.
